io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the SOC IO bus, directly downstream of the SOC top.
- Consumes the SOC's data, port, IOenable and rw outputs.
- Decodes CPU writes to its ports, buffers bytes in a small FIFO, and serialises them 8N1 onto a single tx line.
- Exposes busy/full/overflow status as plain outputs.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 4, byte entries; must be a power of two, >= 2.
- PORT_TX, 16'h0001, IO port: a write enqueues data[7:0].
- PORT_CTRL, 16'h0002, IO port: a write applies control bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- data  in  16  IO write data from SOC; only [7:0] used for TX; [1:0] used for CTRL.
- port  in  16  IO port address.
- IOenable  in  1  high = current access targets IO space.
- rw  in  1  high = write cycle.
- tx  out  1  serial output; idle high.
- busy  out  1  FIFO non-empty or frame in progress.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky: a TX write was dropped.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO empty, FSM IDLE, bit and baud counters 0.
  - Any frame in flight is aborted; tx returns high immediately.
- Write strobes:
  - wr_tx = IOenable & rw & (port==PORT_TX).
  - wr_ctrl = IOenable & rw & (port==PORT_CTRL).
  - Sampled every rising edge; each cycle a strobe is high counts as one write.
  - rw=0 or IOenable=0 is ignored (RAM traffic, reads).
  - Other port values are ignored.
- TX write:
  - FIFO not full: push data[7:0]; data[15:8] discarded.
  - FIFO full: byte dropped, overflow set to 1 at that edge.
  - full is evaluated before the edge: a push while full and a pop in the same cycle still drops the byte.
- CTRL write:
  - data[0]=1 clears overflow.
  - data[1]=1 flushes the FIFO (count to 0); the frame currently shifting completes.
  - If flush and wr_tx occur in the same cycle, the flush wins and the byte is lost; overflow is not set.
- Simultaneous push and pop with FIFO not full: both occur, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: FIFO non-empty at an edge → pop into shift register, bit counter 0, baud counter 0, go START. tx is a registered output and reads 0 from that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]; after CLKS_PER_BIT cycles shift right and increment bit counter; after bit 7 go STOP. LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, FIFO non-empty → pop and go directly to START (back-to-back, no idle gap); otherwise go IDLE.
- Timing:
  - Frame is exactly 10*CLKS_PER_BIT cycles.
  - Write at edge E0 with FIFO empty and FSM IDLE → tx falls at E1 (one-cycle latency).
- Counter widths: baud counter $clog2(CLKS_PER_BIT); bit counter 3 bits; FIFO count $clog2(FIFO_DEPTH)+1.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Status outputs:
  - busy = (state!=IDLE) | (count!=0), combinational from registers.
  - full = (count==FIFO_DEPTH).

Decomposition:
- io_pkg:
  - Port address constants.
  - CTRL bit indices: CTRL_CLR_OVF=0, CTRL_FLUSH=1.
  - tx_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module, sync_fifo:
  - Parameterised width and depth.
  - push, pop, flush inputs; dout, count, full, empty outputs.
  - Same clk and async active-low reset.
- Top contains the decode logic, FSM and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset, then a single TX write of data=16'h12A5 → tx falls one edge later; per-bit levels 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; busy drops to 0 after 40 cycles.
2. Four consecutive TX writes 0x01,0x02,0x03,0x04 → first byte pops immediately, so full is never asserted; four frames go out back-to-back, 160 cycles with no idle high gap beyond stop bits; overflow stays 0.
3. Six TX writes in six consecutive cycles → bytes 1-5 accepted (one popped to the shifter), byte 6 dropped, overflow=1. Then CTRL write data=1 → overflow=0 next edge.
4. Writes with rw=0, with IOenable=0, and to port 16'h0003 → FIFO count stays 0; tx stays 1; busy=0.
5. Three bytes queued, then CTRL write data=2 during the first frame's DATA state → first frame completes; tx stays high afterwards; busy=0.
6. reset pulled low mid-DATA of frame 0x00 → tx=1 asynchronously, before the next edge; after release, FIFO is empty and no further frame is sent.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and types for the IO-bus UART transmitter
package io_pkg;

    // Default IO port addresses decoded by the transmitter
    localparam logic [15:0] IO_PORT_TX   = 16'h0001;
    localparam logic [15:0] IO_PORT_CTRL = 16'h0002;

    // Bit positions inside a CTRL write
    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push, pop and flush
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped; flush discards any same-cycle push
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter on the SOC IO bus
module io_uart_tx
    import io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] PORT_TX      = IO_PORT_TX,
    parameter logic [15:0] PORT_CTRL    = IO_PORT_CTRL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [15:0] port,
    input  logic        IOenable,
    input  logic        rw,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow
);
    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic            wr_tx, wr_ctrl, flush, clr_ovf;
    logic            fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            unused_data_hi;

    tx_state_t       state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;

    assign wr_tx          = IOenable & rw & (port == PORT_TX);
    assign wr_ctrl        = IOenable & rw & (port == PORT_CTRL);
    assign flush          = wr_ctrl & data[CTRL_FLUSH];
    assign clr_ovf        = wr_ctrl & data[CTRL_CLR_OVF];
    assign unused_data_hi = ^data[15:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (data[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx       = tx_q;
    assign full     = fifo_full;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) | (fifo_count != '0);

    // Overflow is sticky; the full flag seen before the edge decides a drop
    always_comb begin
        ovf_d = ovf_q;
        if (wr_tx & fifo_full & ~flush) begin
            ovf_d = 1'b1;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Frame sequencer; tx_d is the line level for the state entered at the edge
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                    tx_d   = 1'b0;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                    tx_d   = shift_q[0];
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        bit_d    = '0;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Registers; reset aborts any frame and drives the line idle at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - self-checking bench for io_uart_tx
module tb_io_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data, port;
    logic        IOenable, rw;
    logic        tx, busy, full, overflow;

    always #5 clk = ~clk;

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .PORT_TX      (16'h0001),
        .PORT_CTRL    (16'h0002)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .port     (port),
        .IOenable (IOenable),
        .rw       (rw),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the current frame and its elapsed cycles
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_pos;
    logic [7:0] m_byte;
    bit         m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_pos    = 0;
        m_ovf    = 0;
    endtask

    // Line level = bit slot (elapsed/CPB) of frame {start, d0..d7, stop}
    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    task automatic model_edge(input logic [15:0] d, input logic [15:0] p,
                              input logic en, input logic w);
        bit wr_tx, wr_ctrl, flush, was_full, frame_done, take;
        wr_tx      = en && w && (p == 16'h0001);
        wr_ctrl    = en && w && (p == 16'h0002);
        flush      = wr_ctrl && d[1];
        was_full   = (m_q.size() == DEPTH);
        frame_done = m_active && (m_pos == 10*CPB - 1);
        take       = (m_q.size() > 0) && (!m_active || frame_done);
        if (m_active) begin
            m_pos++;
            if (frame_done) m_active = 0;
        end
        if (take) begin
            m_byte   = m_q.pop_front();
            m_active = 1;
            m_pos    = 0;
        end
        if (flush) m_q.delete();
        if (wr_tx && !flush) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back(d[7:0]);
        end
        if (wr_ctrl && d[0]) m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_tx"},   tx,       exp_tx());
        check({tag, "_busy"}, busy,     m_active || (m_q.size() != 0));
        check({tag, "_full"}, full,     m_q.size() == DEPTH);
        check({tag, "_ovf"},  overflow, m_ovf);
    endtask

    // One bus cycle: drive at the falling edge, model the rising edge, sample at the next fall
    task automatic cycle(input logic [15:0] d, input logic [15:0] p,
                         input logic en, input logic w, input string tag);
        data = d; port = p; IOenable = en; rw = w;
        @(posedge clk);
        model_edge(d, p, en, w);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(16'($urandom), 16'h0001, 1'b0, 1'b1, tag);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [15:0] p;
        logic        en;
        logic        w;
        logic        e_tx;
        logic        e_busy;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t       vecs[8];
    logic [9:0] t1_levels;
    int         highs;
    int         r;

    initial begin
        vecs[0] = '{16'h12FF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h12FF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0055, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0055, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h0003, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h005A, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        t1_levels = 10'b1101001010;

        reset = 1'b0; data = '0; port = '0; IOenable = 1'b0; rw = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b1;

        // Single frame of 0xA5, bit by bit
        cycle(16'h12A5, 16'h0001, 1'b1, 1'b1, "t1_wr");
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                idle("t1");
                check("t1_bit", tx, t1_levels[k]);
            end
        end
        idle("t1_end");
        check("t1_busy_done", busy, 1'b0);

        // Ignored accesses and first-byte latency from a table
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].d, vecs[i].p, vecs[i].en, vecs[i].w, "tab_model");
            check("tab_tx", tx, vecs[i].e_tx);
            check("tab_busy", busy, vecs[i].e_busy);
            check("tab_full", full, vecs[i].e_full);
            check("tab_ovf", overflow, vecs[i].e_ovf);
        end
        for (int i = 0; i < 45; i++) idle("tab_drain");
        check("tab_drained", busy, 1'b0);

        // Four frames back-to-back
        highs = 0;
        cycle(16'h0001, 16'h0001, 1'b1, 1'b1, "t2_wr");
        for (int i = 0; i < 161; i++) begin
            if (i < 3) cycle(16'(i + 2), 16'h0001, 1'b1, 1'b1, "t2_wr");
            else idle("t2");
            if (i < 160) begin
                if (tx) highs++;
            end
        end
        check("t2_highs", highs == 36, 1'b1);
        check("t2_busy_done", busy, 1'b0);
        check("t2_ovf", overflow, 1'b0);

        // Six writes in six cycles: the sixth is dropped
        for (int i = 0; i < 6; i++) cycle(16'h0010 + 16'(i), 16'h0001, 1'b1, 1'b1, "t3_wr");
        check("t3_ovf_set", overflow, 1'b1);
        check("t3_full", full, 1'b1);
        cycle(16'h0001, 16'h0002, 1'b1, 1'b1, "t3_clr");
        check("t3_ovf_clr", overflow, 1'b0);
        for (int i = 0; i < 220; i++) idle("t3_drain");
        check("t3_drained", busy, 1'b0);

        // Flush during the first frame's data bits
        cycle(16'h0033, 16'h0001, 1'b1, 1'b1, "t5_wr");
        cycle(16'h0044, 16'h0001, 1'b1, 1'b1, "t5_wr");
        cycle(16'h0055, 16'h0001, 1'b1, 1'b1, "t5_wr");
        for (int i = 0; i < 6; i++) idle("t5");
        cycle(16'h0002, 16'h0002, 1'b1, 1'b1, "t5_flush");
        check("t5_busy_mid", busy, 1'b1);
        for (int i = 0; i < 70; i++) idle("t5_after");
        check("t5_tx_high", tx, 1'b1);
        check("t5_busy_done", busy, 1'b0);

        // Asynchronous reset in the middle of a 0x00 frame
        cycle(16'h0000, 16'h0001, 1'b1, 1'b1, "t6_wr");
        cycle(16'h007E, 16'h0001, 1'b1, 1'b1, "t6_wr");
        for (int i = 0; i < 7; i++) idle("t6");
        check("t6_tx_low", tx, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("t6_async_tx", tx, 1'b1);
        check("t6_async_busy", busy, 1'b0);
        check("t6_async_full", full, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) idle("t6_after");
        check("t6_quiet", busy, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      cycle(16'($urandom), 16'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)), "rnd");
            else if (r < 60) cycle(16'($urandom), 16'h0001, 1'b1, 1'b0, "rnd");
            else if (r < 85) cycle(16'($urandom), 16'h0001, 1'b1, 1'b1, "rnd");
            else if (r < 90) cycle(16'($urandom), 16'h0002, 1'b1, 1'b1, "rnd");
            else             cycle(16'($urandom), 16'h0003, 1'b1, 1'b1, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
